// File: rtl/divisor_segmentado_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_seg_pkg
//  Description : Shared types and helpers for the pipelined restoring divider.
//                Holds the width-independent stage control struct and the
//                magnitude/negate functions. Functions work on MAX_W-bit
//                values; callers zero-extend and keep the low WIDTH bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_seg_pkg;

  localparam int MAX_W = 128;

  // Control fields carried by every stage next to ACCU/Q/M/tag
  typedef struct packed {
    logic valid;
    logic sign_num;
    logic sign_den;
    logic signed_op;
    logic dz;
  } seg_ctrl_t;

  localparam int CTRL_W = $bits(seg_ctrl_t);

  function automatic logic [MAX_W-1:0] negate_f(input logic [MAX_W-1:0] x);
    return (~x) + {{(MAX_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [MAX_W-1:0] magnitude_f(input logic [MAX_W-1:0] x,
                                                   input logic             neg);
    return neg ? negate_f(x) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/divisor_segmentado_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : divisor_segmentado_param_if
//  Description : Operand/result handshake bundle for the pipelined divider.
//                master = operand source and result consumer, slave = divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface divisor_segmentado_param_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             Signed;
  logic [WIDTH-1:0] Num;
  logic [WIDTH-1:0] Den;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Coc;
  logic [WIDTH-1:0] Res;
  logic [TAG_W-1:0] tag_out;
  logic             DivZero;

  modport master (
    output in_valid, Signed, Num, Den, tag_in, out_ready,
    input  in_ready, out_valid, Coc, Res, tag_out, DivZero
  );

  modport slave (
    input  in_valid, Signed, Num, Den, tag_in, out_ready,
    output in_ready, out_valid, Coc, Res, tag_out, DivZero
  );
endinterface
`default_nettype wire

// File: rtl/divisor_segmentado_param_stage.sv
`default_nettype none
// ============================================================================
//  Module      : div_seg_stage
//  Description : One registered pipeline stage of the restoring divider,
//                running STEPS iterations of shift/compare/subtract on the
//                {ACCU,Q} pair. Holds its contents while hold_i is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seg_stage
  import div_seg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1,
  parameter int TAG_W = 4
) (
  input  logic                              CLK,
  input  logic                              RSTa,
  input  logic                              hold_i,
  input  logic [CTRL_W+3*WIDTH+TAG_W-1:0]   d_i,
  output logic [CTRL_W+3*WIDTH+TAG_W-1:0]   q_o
);

  typedef struct packed {
    seg_ctrl_t        ctrl;
    logic [WIDTH-1:0] accu;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [TAG_W-1:0] tag;
  } payload_t;

  payload_t       stage_d;
  payload_t       stage_q;
  logic [WIDTH:0] rem_w;
  logic           ge_w;

  // STEPS restoring iterations; the extra remainder bit catches the shifted-out MSB
  always_comb begin
    stage_d = d_i;
    rem_w   = '0;
    ge_w    = 1'b0;
    for (int s = 0; s < STEPS; s++) begin
      rem_w = {stage_d.accu, stage_d.q[WIDTH-1]};
      ge_w  = (rem_w >= {1'b0, stage_d.m});
      if (ge_w) begin
        rem_w = rem_w - {1'b0, stage_d.m};
      end
      stage_d.accu = rem_w[WIDTH-1:0];
      stage_d.q    = {stage_d.q[WIDTH-2:0], ge_w};
    end
  end

  // Stage register: cleared asynchronously, frozen during a downstream stall
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      stage_q <= '0;
    end else if (!hold_i) begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule
`default_nettype wire

// File: rtl/divisor_segmentado_param.sv
`default_nettype none
// ============================================================================
//  Module      : divisor_segmentado_param
//  Description : Pipelined restoring divider, signed/unsigned, with tag
//                sideband and valid/ready flow control. Pipe: capture,
//                magnitude prep, WIDTH/STEPS iteration stages, registered
//                sign correction. Latency WIDTH/STEPS + 2, one op per cycle.
//                Define DIV_ZERO_DETECT_EN to flag Den == 0 (Coc = all ones,
//                Res = Num, DivZero = 1); otherwise DivZero is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module divisor_segmentado_param
  import div_seg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1,
  parameter int TAG_W = 4
) (
  input  logic                       CLK,
  input  logic                       RSTa,
  divisor_segmentado_param_if.slave  bus
);

  localparam int STAGES = WIDTH / STEPS;

  if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > MAX_W / 2) begin : g_bad_width
    $error("divisor_segmentado_param: WIDTH must be even and in 4..%0d", MAX_W / 2);
  end
  if (STEPS < 1 || (WIDTH % STEPS) != 0) begin : g_bad_steps
    $error("divisor_segmentado_param: WIDTH must be a multiple of STEPS");
  end

  typedef struct packed {
    logic             valid;
    logic             signed_op;
    logic             dz;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic [TAG_W-1:0] tag;
  } cap_t;

  typedef struct packed {
    seg_ctrl_t        ctrl;
    logic [WIDTH-1:0] accu;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [TAG_W-1:0] tag;
  } payload_t;

  localparam int PW = $bits(payload_t);

  cap_t             cap_d, cap_q;
  payload_t         prep_d, prep_q;
  payload_t         last_w;
  logic [PW-1:0]    chain_w [0:STAGES];
  logic             stall_w;
  logic             dz_in_w;
  logic             sn_w, sd_w, neg_coc_w, neg_res_w;
  logic [MAX_W-1:0] num_mag_w, den_mag_w, coc_neg_w, res_neg_w;
  logic             out_valid_d, out_valid_q, dz_d, dz_q;
  logic [WIDTH-1:0] coc_d, coc_q, res_d, res_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic             unused_w;

  // The whole pipe freezes only when a finished result is not being taken
  assign stall_w      = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall_w;

`ifdef DIV_ZERO_DETECT_EN
  assign dz_in_w = (bus.Den == '0);
`else
  assign dz_in_w = 1'b0;
`endif

  // Capture: an idle input injects a bubble because valid follows in_valid
  always_comb begin
    cap_d           = '0;
    cap_d.valid     = bus.in_valid;
    cap_d.signed_op = bus.Signed;
    cap_d.dz        = dz_in_w;
    cap_d.num       = bus.Num;
    cap_d.den       = bus.Den;
    cap_d.tag       = bus.tag_in;
  end

  // Magnitude prep; a divide-by-zero op keeps Num raw so it reappears as Res
  assign sn_w      = cap_q.signed_op & cap_q.num[WIDTH-1];
  assign sd_w      = cap_q.signed_op & cap_q.den[WIDTH-1];
  assign num_mag_w = magnitude_f({{(MAX_W-WIDTH){1'b0}}, cap_q.num}, sn_w & ~cap_q.dz);
  assign den_mag_w = magnitude_f({{(MAX_W-WIDTH){1'b0}}, cap_q.den}, sd_w & ~cap_q.dz);

  // Build the first iteration payload from the captured operands
  always_comb begin
    prep_d                = '0;
    prep_d.ctrl.valid     = cap_q.valid;
    prep_d.ctrl.sign_num  = sn_w;
    prep_d.ctrl.sign_den  = sd_w;
    prep_d.ctrl.signed_op = cap_q.signed_op;
    prep_d.ctrl.dz        = cap_q.dz;
    prep_d.accu           = '0;
    prep_d.q              = num_mag_w[WIDTH-1:0];
    prep_d.m              = den_mag_w[WIDTH-1:0];
    prep_d.tag            = cap_q.tag;
  end

  // Input-side registers: capture and prep, both held during a stall
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      cap_q  <= '0;
      prep_q <= '0;
    end else if (!stall_w) begin
      cap_q  <= cap_d;
      prep_q <= prep_d;
    end
  end

  assign chain_w[0] = prep_q;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    div_seg_stage #(
      .WIDTH (WIDTH),
      .STEPS (STEPS),
      .TAG_W (TAG_W)
    ) u_stage (
      .CLK    (CLK),
      .RSTa   (RSTa),
      .hold_i (stall_w),
      .d_i    (chain_w[i]),
      .q_o    (chain_w[i+1])
    );
  end

  assign last_w    = chain_w[STAGES];
  assign neg_coc_w = last_w.ctrl.signed_op & (last_w.ctrl.sign_num ^ last_w.ctrl.sign_den)
                     & ~last_w.ctrl.dz;
  assign neg_res_w = last_w.ctrl.signed_op & last_w.ctrl.sign_num & ~last_w.ctrl.dz;
  assign coc_neg_w = negate_f({{(MAX_W-WIDTH){1'b0}}, last_w.q});
  assign res_neg_w = negate_f({{(MAX_W-WIDTH){1'b0}}, last_w.accu});

  // Sign correction: quotient negated on differing signs, remainder follows Num
  always_comb begin
    out_valid_d = last_w.ctrl.valid;
    coc_d       = neg_coc_w ? coc_neg_w[WIDTH-1:0] : last_w.q;
    res_d       = neg_res_w ? res_neg_w[WIDTH-1:0] : last_w.accu;
    tag_d       = last_w.tag;
    dz_d        = last_w.ctrl.dz;
  end

  // Output register: the presented result stays put until it is taken
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      out_valid_q <= 1'b0;
      coc_q       <= '0;
      res_q       <= '0;
      tag_q       <= '0;
      dz_q        <= 1'b0;
    end else if (!stall_w) begin
      out_valid_q <= out_valid_d;
      coc_q       <= coc_d;
      res_q       <= res_d;
      tag_q       <= tag_d;
      dz_q        <= dz_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Coc       = coc_q;
  assign bus.Res       = res_q;
  assign bus.tag_out   = tag_q;
  assign bus.DivZero   = dz_q;

  // Divisor and upper helper bits are not needed past the last stage
  assign unused_w = ^{last_w.m, num_mag_w[MAX_W-1:WIDTH], den_mag_w[MAX_W-1:WIDTH],
                      coc_neg_w[MAX_W-1:WIDTH], res_neg_w[MAX_W-1:WIDTH]};

endmodule
`default_nettype wire

// File: tb/tb_divisor_segmentado_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divisor_segmentado_param
//  Description : Directed self-checking bench for divisor_segmentado_param,
//                WIDTH=8, STEPS=2 (latency 6). Divide-by-zero vectors run
//                only when DIV_ZERO_DETECT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divisor_segmentado_param;

  localparam int W   = 8;
  localparam int TW  = 4;
  localparam int LAT = 6;

  logic clk;
  logic rsta;
  int   n_checks;
  int   n_pass;

  divisor_segmentado_param_if #(.WIDTH(W), .TAG_W(TW)) u_if ();

  divisor_segmentado_param #(
    .WIDTH (W),
    .STEPS (2),
    .TAG_W (TW)
  ) dut (
    .CLK  (clk),
    .RSTa (rsta),
    .bus  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op, then wait (bounded) for its result and compare everything
  task automatic run_op(input string name, input logic sgn, input logic [W-1:0] n,
                        input logic [W-1:0] d, input logic [TW-1:0] tg,
                        input logic [W-1:0] ec, input logic [W-1:0] er, input logic edz);
    int lat;
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b1;
    u_if.Signed    = sgn;
    u_if.Num       = n;
    u_if.Den       = d;
    u_if.tag_in    = tg;
    #1;
    chk({name, " in_ready"}, u_if.in_ready, 1);
    tick();
    u_if.in_valid = 1'b0;
    lat = 0;
    while (!u_if.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({name, " latency"}, lat, LAT);
    chk({name, " Coc"}, u_if.Coc, ec);
    chk({name, " Res"}, u_if.Res, er);
    chk({name, " tag_out"}, u_if.tag_out, tg);
    chk({name, " DivZero"}, u_if.DivZero, edz);
    tick();
  endtask

  logic [W-1:0]  b2b_coc [8] = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd11, 8'd11, 8'd11};
  logic [W-1:0]  b2b_res [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd2};
  logic [TW-1:0] got_tag [8];
  logic [W-1:0]  got_coc [8];
  logic [W-1:0]  got_res [8];

  initial begin
    int  idx, got, low, stall_left, extra;
    bit  seen, acc, take;
    n_checks = 0;
    n_pass   = 0;
    rsta           = 1'b1;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    u_if.Signed    = 1'b0;
    u_if.Num       = '0;
    u_if.Den       = '0;
    u_if.tag_in    = '0;
    #2 rsta = 1'b0;
    #10;
    chk("rst out_valid", u_if.out_valid, 0);
    chk("rst Coc", u_if.Coc, 0);
    chk("rst Res", u_if.Res, 0);
    chk("rst tag_out", u_if.tag_out, 0);
    chk("rst DivZero", u_if.DivZero, 0);
    chk("rst in_ready", u_if.in_ready, 1);
    rsta = 1'b1;

    run_op("u100/7", 1'b0, 8'd100, 8'd7, 4'd3, 8'd14, 8'd2, 1'b0);
    run_op("s-7/2", 1'b1, 8'hF9, 8'h02, 4'd1, 8'hFD, 8'hFF, 1'b0);
    run_op("s7/-2", 1'b1, 8'h07, 8'hFE, 4'd2, 8'hFD, 8'h01, 1'b0);
    run_op("smin/-1", 1'b1, 8'h80, 8'hFF, 4'd4, 8'h80, 8'h00, 1'b0);
    run_op("u200/-1", 1'b0, 8'd200, 8'hFF, 4'd6, 8'd0, 8'd200, 1'b0);
`ifdef DIV_ZERO_DETECT_EN
    run_op("s2a/0", 1'b1, 8'h2A, 8'h00, 4'd5, 8'hFF, 8'h2A, 1'b1);
    run_op("u9c/0", 1'b0, 8'h9C, 8'h00, 4'd7, 8'hFF, 8'h9C, 1'b1);
`endif

    // Back-to-back stream with a 3-cycle consumer stall on the first result
    idx = 0; got = 0; low = 0; stall_left = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (u_if.out_valid && !seen) begin
        seen       = 1'b1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        u_if.out_ready = 1'b0;
        stall_left--;
      end else begin
        u_if.out_ready = 1'b1;
      end
      if (idx < 8) begin
        u_if.in_valid = 1'b1;
        u_if.Signed   = 1'b0;
        u_if.Num      = W'(50 + idx);
        u_if.Den      = 8'd5;
        u_if.tag_in   = TW'(idx);
      end else begin
        u_if.in_valid = 1'b0;
      end
      #1;
      if (!u_if.in_ready) low++;
      acc  = u_if.in_valid && u_if.in_ready;
      take = u_if.out_valid && u_if.out_ready;
      if (take) begin
        if (got < 8) begin
          got_tag[got] = u_if.tag_out;
          got_coc[got] = u_if.Coc;
          got_res[got] = u_if.Res;
        end
        got++;
      end
      tick();
      if (acc) idx++;
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      if (u_if.out_valid) extra++;
      tick();
    end
    chk("b2b accepted", idx, 8);
    chk("b2b results", got, 8);
    chk("b2b in_ready low cycles", low, 3);
    chk("b2b extra results", extra, 0);
    for (int k = 0; k < 8; k++) begin
      if (k < got) begin
        chk($sformatf("b2b tag[%0d]", k), got_tag[k], k);
        chk($sformatf("b2b Coc[%0d]", k), got_coc[k], b2b_coc[k]);
        chk($sformatf("b2b Res[%0d]", k), got_res[k], b2b_res[k]);
      end
    end

    // Reset with three ops in flight, the first one sitting at the output
    u_if.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      u_if.in_valid = 1'b1;
      u_if.Signed   = 1'b0;
      u_if.Num      = W'(90 + k);
      u_if.Den      = 8'd9;
      u_if.tag_in   = TW'(9 + k);
      tick();
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre-reset out_valid", u_if.out_valid, 1);
    #2 rsta = 1'b0;
    #1;
    chk("async rst out_valid", u_if.out_valid, 0);
    chk("async rst Coc", u_if.Coc, 0);
    chk("async rst tag_out", u_if.tag_out, 0);
    chk("async rst in_ready", u_if.in_ready, 1);
    tick();
    rsta           = 1'b1;
    u_if.out_ready = 1'b1;
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      if (u_if.out_valid) extra++;
      tick();
    end
    chk("post-reset ghost results", extra, 0);
    run_op("post-rst 77/8", 1'b0, 8'd77, 8'd8, 4'd12, 8'd9, 8'd5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/divisor_segmentado_param.md
DIVISOR_SEGMENTADO_PARAM -- requirements
Module: divisor_segmentado_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; even, >= 4.
REQ-002 SHALL have parameter STEPS, default 1: restoring iterations per pipeline stage; WIDTH % STEPS == 0, else elaboration error.
REQ-003 SHALL have parameter TAG_W, default 4: sideband tag width.
REQ-004 SHALL have port CLK  input  1  rising-edge clock.
REQ-005 SHALL have port RSTa  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operand pair offered.
REQ-007 SHALL have port in_ready  output  1  operand pair accepted this cycle if in_valid.
REQ-008 SHALL have port Signed  input  1  1 = two's-complement operation, 0 = unsigned; sampled with operands.
REQ-009 SHALL have port Num  input  WIDTH  dividend.
REQ-010 SHALL have port Den  input  WIDTH  divisor.
REQ-011 SHALL have port tag_in  input  TAG_W  sideband, returned unchanged with the result.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have ports Coc and Res  output  WIDTH each  quotient and remainder.
REQ-015 SHALL have port tag_out  output  TAG_W  tag of the current result.
REQ-016 SHALL have port DivZero  output  1  result came from Den == 0.

Function
REQ-017 SHALL use pipeline layout: input stage (capture, magnitude, sign save) + STAGES = WIDTH/STEPS iteration stages + output stage (sign correction, registered).
REQ-018 SHALL have latency L = STAGES + 2: an op accepted at edge n produces out_valid at edge n+L when there is no stall.
REQ-019 SHALL have throughput of one op per cycle; each stage carries its own valid bit; ops stay in order.
REQ-020 SHALL define stall = out_valid & ~out_ready; while stall, every stage holds its contents; in_ready = ~stall (combinational).
REQ-021 SHALL ignore the offer when in_valid=1 and in_ready=0; the source holds the offer.
REQ-022 SHALL, while not stalled, advance every stage each cycle; an empty input injects a bubble with valid=0; out_valid may drop to 0 between results.
REQ-023 SHALL implement each iteration as: shift {ACCU,Q} left 1; if ACCU >= M, then ACCU -= M and Q[0] = 1.
REQ-024 SHALL, when Signed=1, use the magnitudes of Num and Den, truncate the quotient toward zero, negate Coc when the operand signs differ, and give Res the sign of Num.
REQ-025 SHALL, when Signed=0, apply no magnitude conversion and no sign correction.
REQ-026 SHALL give MIN/-1 (Signed=1) the result Coc = MIN (wraps), Res = 0, DivZero = 0.
REQ-027 SHALL hold Coc, Res, tag_out and DivZero stable while out_valid=1 and out_ready=0.

Reset
REQ-028 SHALL, on RSTa low, immediately clear all stage valid bits and data registers regardless of CLK.
REQ-029 SHALL drive these values in reset: out_valid=0, Coc=0, Res=0, tag_out=0, DivZero=0, in_ready=1.
REQ-030 SHALL discard ops in flight at reset; no result for them appears after release.
REQ-031 SHALL be able to accept an op at the first edge after RSTa deasserts.

Configuration
REQ-032 SHALL use macro DIV_ZERO_DETECT_EN to compile divide-by-zero detection in or out.
REQ-033 SHALL, with the macro defined, flag Den == 0 at the input stage and carry the flag down the pipe; the result is then Coc = all ones, Res = Num (unmodified), DivZero = 1, regardless of Signed.
REQ-034 SHALL, with the macro undefined, tie DivZero to 0 and return the raw algorithm result for Den == 0; that result is unspecified to the consumer.

Structure
REQ-035 SHALL place in package div_seg_pkg: the stage payload struct (valid, sign_num, sign_den, signed_op, dz, ACCU, Q, M, tag), parameterised via WIDTH/TAG_W typedefs, and functions for magnitude and negate.
REQ-036 SHALL implement each iteration stage in one sub-module, div_seg_stage (STEPS iterations, registered, with hold-on-stall input), instantiated STAGES times in a generate loop.

Verification
Bench configuration: WIDTH=8, STEPS=2 (L=6).
REQ-037 SHALL cover: unsigned 100/7 at cycle 0, tag 3 -> at cycle 6 out_valid=1, Coc=14, Res=2, tag_out=3.
REQ-038 SHALL cover: Signed -7/2 (0xF9/0x02) -> Coc=0xFD (-3), Res=0xFF (-1); and 7/-2 -> Coc=0xFD, Res=0x01.
REQ-039 SHALL cover: Signed 0x80/0xFF -> Coc=0x80, Res=0x00, DivZero=0.
REQ-040 SHALL cover, with DIV_ZERO_DETECT_EN: 0x2A/0x00 -> Coc=0xFF, Res=0x2A, DivZero=1.
REQ-041 SHALL cover: 8 back-to-back ops with tags 0..7, out_ready low for 3 cycles after the first result -> in_ready low for exactly those 3 cycles, no loss or duplication, tags out in order 0..7.
REQ-042 SHALL cover: RSTa pulsed low with 3 ops in flight -> out_valid=0 immediately, no result for them after release, a new op then completes after L cycles.
